if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_pc_reg.sv | 37 +++
 rtl/if_fetch.sv | 112 +++++++++++
 tb/tb_if_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, the word width, the default PC step and a
// word-alignment helper used by the PC register.
package if_fetch_pkg;

  localparam int          WORD_W          = 32;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk_i, rst_i   clock / synchronous active-high reset (loads RESET_PC)
//   step_i         advance by PC_STEP (modulo 2^32)
//   redirect_i     load the word-aligned target_i; wins over step_i
//   target_i       redirect address
//   pc_o           current PC
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter logic [WORD_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] target_i,
  output logic [WORD_W-1:0] pc_o
);

  logic [WORD_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)  pc_d = align_word(target_i);
    else if (step_i) pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: IDLE/FETCH/HOLD FSM issuing one instruction-memory
// request at a time and presenting each returned word to IF/ID until the
// hazard unit lets it advance.
// Ports:
//   clk_i, rst_i                      clock / synchronous active-high reset
//   start_i                           leave IDLE (ignored afterwards)
//   stall_i                           freeze delivery and redirect
//   PC_write_i                        permission to advance past the held inst
//   branch_taken_i, branch_target_i   redirect from ID
//   imem_req_o, imem_addr_o           request, held until imem_ack_i
//   imem_ack_i, imem_data_i           one-cycle ack with data
//   PC_o, inst_o, valid_o             delivered instruction to IF/ID
//   fetch_cnt_o                       number of instructions accepted
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              PC_write_i,
  input  logic              branch_taken_i,
  input  logic [WORD_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [WORD_W-1:0] imem_data_i,
  output logic [WORD_W-1:0] PC_o,
  output logic [WORD_W-1:0] inst_o,
  output logic              valid_o,
  output logic [WORD_W-1:0] fetch_cnt_o
);

  fetch_state_e      state_q;
  logic              squash_q;
  logic [WORD_W-1:0] hold_addr_q;
  logic [WORD_W-1:0] pc_out_q, inst_q, cnt_q;
  logic              valid_q;
  logic [WORD_W-1:0] pc;
  logic              active, redirect, advance;

  assign active   = (state_q == FETCH) || (state_q == HOLD);
  assign redirect = active && branch_taken_i && !stall_i;
  assign advance  = (state_q == HOLD) && PC_write_i && !stall_i && !branch_taken_i;

  if_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .step_i     (advance),
    .redirect_i (redirect),
    .target_i   (branch_target_i),
    .pc_o       (pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      squash_q    <= 1'b0;
      hold_addr_q <= '0;
      pc_out_q    <= '0;
      inst_q      <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_q <= FETCH;
        FETCH: begin
          if (imem_ack_i) begin
            // Stale (squashed) data or a same-cycle redirect: drop the word
            // and immediately refetch at the already-updated PC.
            if (squash_q || redirect) begin
              squash_q <= 1'b0;
            end else begin
              inst_q   <= imem_data_i;
              pc_out_q <= pc;
              valid_q  <= 1'b1;
              state_q  <= HOLD;
            end
          end else if (redirect && !squash_q) begin
            // The bus request must finish at its original address, so
            // remember it while the PC moves on to the target.
            squash_q    <= 1'b1;
            hold_addr_q <= pc;
          end
        end
        HOLD: begin
          if (redirect || advance) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            state_q <= FETCH;
            if (advance) cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state_q == FETCH);
  assign imem_addr_o = squash_q ? hold_addr_q : pc;
  assign PC_o        = pc_out_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stall, pcw, br, ack;
  logic [31:0] tgt, data;
  logic        req, valid;
  logic [31:0] addr, pc_o, inst, cnt;

  logic        start2, ack2, req2, valid2;
  logic [31:0] data2, addr2, pc2, inst2, cnt2;

  if_fetch dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .PC_write_i(pcw),
    .branch_taken_i(br), .branch_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_data_i(data), .PC_o(pc_o), .inst_o(inst), .valid_o(valid),
    .fetch_cnt_o(cnt)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .stall_i(1'b0), .PC_write_i(1'b1),
    .branch_taken_i(1'b0), .branch_target_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_data_i(data2), .PC_o(pc2), .inst_o(inst2), .valid_o(valid2),
    .fetch_cnt_o(cnt2)
  );

  int          nerr = 0, nchk = 0;
  logic [31:0] exp_pc = 32'h0, exp_cnt = 32'h0;
  bit          started = 0, pend = 0;
  logic [31:0] pend_addr = 32'h0;
  int          wait_n = 0, lat = 2;
  logic [31:0] req_log[$];
  logic [31:0] log2[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory responders, edge, reference-model update, checks.
  task automatic cycle();
    logic vprev, ackp;
    bit   sp;
    ack = 1'b0; data = 32'hDEAD_BEEF;
    if (req === 1'b1) begin
      if (!pend) begin
        pend = 1; pend_addr = addr; wait_n = lat; req_log.push_back(addr);
      end else chk("addr_stable", addr, pend_addr);
      if (wait_n == 0) begin ack = 1'b1; data = mem_word(pend_addr); pend = 0; end
      else wait_n--;
    end
    ack2 = 1'b0; data2 = 32'hDEAD_BEEF;
    if (req2 === 1'b1) begin ack2 = 1'b1; data2 = mem_word(addr2); log2.push_back(addr2); end
    vprev = valid; ackp = ack; sp = started;
    @(posedge clk);
    if (rst) begin
      exp_pc = 32'h0; exp_cnt = 32'h0; started = 0; pend = 0;
    end else begin
      if (started && br && !stall) exp_pc = {tgt[31:2], 2'b00};
      else if (vprev === 1'b1 && pcw && !stall) begin exp_pc += 32'd4; exp_cnt += 32'd1; end
      if (start) started = 1;
    end
    #1;
    chk("fetch_cnt", cnt, exp_cnt);
    if (valid !== 1'b1) chk("inst_zero", inst, 32'h0);
    else begin
      chk("pc_o", pc_o, exp_pc);
      chk("inst_o", inst, mem_word(exp_pc));
    end
    if (!rst && vprev === 1'b1)
      chk("valid_keep", {31'b0, valid}, {31'b0, !(sp && !stall && (br || pcw))});
    if (!rst && vprev !== 1'b1 && valid === 1'b1)
      chk("ack_before_valid", {31'b0, ackp}, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1; start = 0; br = 0; stall = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  logic [31:0] pc0, i0, d_addr, cnt0;

  initial begin
    rst = 1; start = 0; stall = 0; pcw = 1; br = 0; tgt = 0; ack = 0; data = 0;
    start2 = 0; ack2 = 0; data2 = 0;

    // Reset state and IDLE before start
    do_reset();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    cycle(); cycle();
    chk("idle_req", {31'b0, req}, 32'h0);

    // Sequential fetch with 2-cycle memory latency
    req_log.delete(); lat = 2; pcw = 1;
    pulse_start();
    for (int i = 0; i < 60 && cnt !== 32'd3; i++) cycle();
    chk("seq_cnt", cnt, 32'd3);
    if (req_log.size() >= 3) begin
      chk("seq_a0", req_log[0], 32'h0);
      chk("seq_a1", req_log[1], 32'h4);
      chk("seq_a2", req_log[2], 32'h8);
    end else chk("seq_nreq", req_log.size(), 32'd3);

    // Hold with PC_write_i low for 5 cycles
    pcw = 0;
    for (int i = 0; i < 30 && valid !== 1'b1; i++) cycle();
    chk("hold_valid", {31'b0, valid}, 32'h1);
    pc0 = pc_o; i0 = inst;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_pc", pc_o, pc0);
      chk("hold_inst", inst, i0);
    end
    pcw = 1; req_log.delete();
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
    if (req_log.size() > 0) chk("hold_next", req_log[0], pc0 + 32'd4);
    else chk("hold_next_to", 32'd0, 32'd1);

    // Redirect while the fetch of 0x10 is outstanding
    do_reset(); lat = 2; pcw = 1;
    pulse_start();
    for (int i = 0; i < 100 && !(req === 1'b1 && addr === 32'h10 && !pend); i++) cycle();
    chk("redir_found", addr, 32'h10);
    req_log.delete();
    br = 1; tgt = 32'h0000_0103;
    cycle();
    br = 0;
    for (int i = 0; i < 30 && req_log.size() < 2; i++) begin
      cycle();
      chk("redir_never_valid", {31'b0, valid}, 32'h0);
    end
    chk("redir_nreq", req_log.size(), 32'd2);
    if (req_log.size() >= 2) chk("redir_addr", req_log[1], 32'h100);

    // Stall with branch held 3 cycles; ack lands mid-stall
    for (int i = 0; i < 30 && valid !== 1'b1; i++) cycle();
    chk("redir_deliver", pc_o, 32'h100);
    for (int i = 0; i < 10 && !(req === 1'b1 && !pend); i++) cycle();
    d_addr = addr; cnt0 = cnt;
    lat = 1; stall = 1; br = 1; tgt = 32'h200;
    cycle(); cycle(); cycle();
    chk("stall_valid", {31'b0, valid}, 32'h1);
    chk("stall_pc", pc_o, d_addr);
    chk("stall_inst", inst, mem_word(d_addr));
    chk("stall_cnt", cnt, cnt0);
    stall = 0; br = 0;
    req_log.delete();
    cycle();
    chk("stall_release_valid", {31'b0, valid}, 32'h0);
    chk("stall_release_cnt", cnt, cnt0 + 32'd1);
    cycle();
    if (req_log.size() > 0) chk("stall_next", req_log[0], d_addr + 32'd4);
    else chk("stall_next_to", 32'd0, 32'd1);

    // Random traffic against the reference model
    do_reset();
    pulse_start();
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      pcw   = ($urandom_range(0, 3) != 0);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = $urandom;
      lat   = $urandom_range(0, 3);
      cycle();
    end
    stall = 0; br = 0; pcw = 1;

    // Reset landing on the same cycle as an ack
    do_reset(); lat = 1;
    pulse_start();
    for (int i = 0; i < 60 && cnt < 32'd2; i++) cycle();
    for (int i = 0; i < 10 && !(req === 1'b1 && !pend); i++) cycle();
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rack_valid", {31'b0, valid}, 32'h0);
    chk("rack_cnt", cnt, 32'h0);
    chk("rack_req", {31'b0, req}, 32'h0);
    chk("rack_pc_o", pc_o, 32'h0);
    chk("rack_inst", inst, 32'h0);
    pulse_start();
    req_log.delete();
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
    if (req_log.size() > 0) chk("rack_first", req_log[0], 32'h0);
    else chk("rack_first_to", 32'd0, 32'd1);

    // Non-zero RESET_PC wrapping through 2^32
    log2.delete();
    start2 = 1;
    for (int i = 0; i < 30 && log2.size() < 3; i++) cycle();
    chk("wrap_nreq", {31'b0, log2.size() >= 3}, 32'h1);
    if (log2.size() >= 3) begin
      chk("wrap_a0", log2[0], 32'hFFFF_FFF8);
      chk("wrap_a1", log2[1], 32'hFFFF_FFFC);
      chk("wrap_a2", log2[2], 32'h0000_0000);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
